// File: rtl/gcd_pkg.sv
// Shared definitions for the sequential GCD engine and its remainder unit.
package gcd_pkg;

  localparam int W    = 16;
  localparam int ITER = W;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CHECK = 3'd1,
    S_MOD   = 3'd2,
    S_SWAP  = 3'd3,
    S_FIN   = 3'd4
  } state_t;

endpackage

// File: rtl/urem_seq.sv
// Restoring shift-subtract remainder unit: r = a mod b after W iterations.
module urem_seq
  import gcd_pkg::*;
#(
  parameter int W = gcd_pkg::ITER
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] r,
  output logic         rdy
);

  localparam int CW = $clog2(W) + 1;

  logic [W-1:0]  r_rem;
  logic [W-1:0]  r_quo;
  logic [CW-1:0] r_cnt;
  logic          r_rdy;

  logic [W-1:0] w_rem_src;
  logic [W-1:0] w_quo_src;
  logic [W:0]   w_trial;
  logic [W-1:0] w_rem_nxt;

  // The start cycle already performs the first iteration from R = 0, Q = a,
  // so the whole remainder takes exactly W clock edges.
  always_comb begin
    w_rem_src = start ? '0 : r_rem;
    w_quo_src = start ? a  : r_quo;
    w_trial   = {w_rem_src, w_quo_src[W-1]};
    if (w_trial >= {1'b0, b}) begin
      w_rem_nxt = W'(w_trial - {1'b0, b});
    end else begin
      w_rem_nxt = w_trial[W-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rem <= '0;
      r_quo <= '0;
      r_cnt <= '0;
      r_rdy <= 1'b0;
    end else if (start) begin
      r_rem <= w_rem_nxt;
      r_quo <= {w_quo_src[W-2:0], 1'b0};
      r_cnt <= CW'(W - 1);
      r_rdy <= 1'b0;
    end else if (r_cnt != '0) begin
      r_rem <= w_rem_nxt;
      r_quo <= {w_quo_src[W-2:0], 1'b0};
      r_cnt <= r_cnt - 1'b1;
      r_rdy <= (r_cnt == CW'(1));
    end
  end

  assign r   = r_rem;
  assign rdy = r_rdy;

endmodule

// File: rtl/gcd_seq.sv
// Sequential Euclidean GCD of two signed operands; result is gcd(|X|, |Y|).
module gcd_seq
  import gcd_pkg::*;
#(
  parameter int W = gcd_pkg::W
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                L,
  input  logic signed [W-1:0] X,
  input  logic signed [W-1:0] Y,
  output logic        [W-1:0] O,
  output logic                busy,
  output logic                done,
  output logic                ovf
);

  localparam logic [W-1:0] MIN_MAG = {1'b1, {(W-1){1'b0}}};

  state_t       r_state;
  logic [W-1:0] r_a;
  logic [W-1:0] r_b;
  logic [W-1:0] r_o;
  logic         r_busy;
  logic         r_done;
  logic         r_ovf;

  logic         w_start;
  logic [W-1:0] w_rem;
  logic         w_rdy;

  // Two's-complement magnitude; the most negative value maps to MIN_MAG.
  function automatic logic [W-1:0] mag(input logic signed [W-1:0] v);
    logic [W-1:0] u;
    u = v;
    return v[W-1] ? W'(~u + 1'b1) : u;
  endfunction

  assign w_start = (r_state == S_CHECK) && (r_b != '0);

  urem_seq #(.W(W)) u_urem (
    .clk   (clk),
    .rst_n (rst_n),
    .start (w_start),
    .a     (r_a),
    .b     (r_b),
    .r     (w_rem),
    .rdy   (w_rdy)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_o     <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (L) begin
            r_a     <= mag(X);
            r_b     <= mag(Y);
            r_busy  <= 1'b1;
            r_state <= S_CHECK;
          end
        end
        S_CHECK: r_state <= (r_b == '0) ? S_FIN : S_MOD;
        S_MOD: begin
          if (w_rdy) r_state <= S_SWAP;
        end
        S_SWAP: begin
          r_a     <= r_b;
          r_b     <= w_rem;
          r_state <= S_CHECK;
        end
        S_FIN: begin
          r_o     <= r_a;
          r_ovf   <= (r_a == MIN_MAG);
          r_done  <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign O    = r_o;
  assign busy = r_busy;
  assign done = r_done;
  assign ovf  = r_ovf;

endmodule
